// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-to-serial frame transmitter. Bytes arrive over a valid/ready
//   handshake into a one-entry holding register. Each byte is sent as one
//   frame: a one-cycle set_o strobe followed by DATA_W bits, MSB first, one
//   per clock. GAP_CYCLES idle cycles separate consecutive frames.
//
// Ports
//   clk_i        clock, rising edge
//   rst          asynchronous, active-high reset
//   data_i       byte to transmit
//   valid_i      data_i valid; taken on an edge where ready_o is high
//   ready_o      holding register empty
//   set_o        frame-start strobe, one cycle per frame
//   bit_o        serial data, valid for DATA_W cycles after set_o
//   busy_o       high while a frame (including its gap) is in progress
//   done_o       one-cycle pulse alongside the last (LSB) bit
//   frame_cnt_o  frames completed, wraps modulo 2^CNT_W
`timescale 1ns/1ps
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              set_o,
  output logic              bit_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  frame_cnt_o
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

  state_e             state_q, state_d;
  logic               hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               set_q, set_d;
  logic               bit_q, bit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               take_hold;

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    take_hold    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_valid_q) take_hold = 1'b1;
      end
      LOAD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt_q == '0) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LAST;
          end else if (hold_valid_q) begin
            // No gap configured: the next set_o follows the LSB directly.
            take_hold = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          if (hold_valid_q) take_hold = 1'b1;
          else              state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A transfer needs a full hold and an accept needs an empty one, so the
    // two can never land on the same edge.
    if (take_hold) begin
      state_d      = LOAD;
      shift_d      = hold_q;
      bit_cnt_d    = BIT_LAST;
      hold_valid_d = 1'b0;
    end else if (valid_i && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_d       = data_i;
    end

    // Outputs are decoded from the next state so they come straight off flops.
    set_d  = (state_d == LOAD);
    busy_d = (state_d != IDLE);
    done_d = (state_d == SHIFT) && (bit_cnt_d == '0);
    bit_d  = (state_d == SHIFT) ? shift_d[bit_cnt_d] : 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      set_q        <= 1'b0;
      bit_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      set_q        <= set_d;
      bit_q        <= bit_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ready_o     = ~hold_valid_q;
  assign set_o       = set_q;
  assign bit_o       = bit_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
//   Bench for serial_frame_tx. Two instances share clock and reset:
//   instance a (GAP_CYCLES=1, CNT_W=16) and instance b (GAP_CYCLES=0, CNT_W=4).
//   A frame-level reference model predicts every output of both instances
//   each cycle; directed sequences cover reset, frame content, back-to-back
//   spacing, reset mid-frame and counter wrap.
`timescale 1ns/1ps
module tb_serial_frame_tx;

  localparam int DW    = 8;
  localparam int GAP_A = 1;
  localparam int GAP_B = 0;

  logic        clk_i = 1'b0;
  logic        rst   = 1'b1;
  logic        va = 1'b0, vb = 1'b0;
  logic [7:0]  da = 8'h00, db = 8'h00;
  logic        ra, sa, ba, bua, doa;
  logic        rb, sb, bb, bub, dob;
  logic [15:0] fca;
  logic [3:0]  fcb;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_frame_tx #(.DATA_W(DW), .GAP_CYCLES(GAP_A), .CNT_W(16)) dut_a (
    .clk_i(clk_i), .rst(rst), .data_i(da), .valid_i(va), .ready_o(ra),
    .set_o(sa), .bit_o(ba), .busy_o(bua), .done_o(doa), .frame_cnt_o(fca));

  serial_frame_tx #(.DATA_W(DW), .GAP_CYCLES(GAP_B), .CNT_W(4)) dut_b (
    .clk_i(clk_i), .rst(rst), .data_i(db), .valid_i(vb), .ready_o(rb),
    .set_o(sb), .bit_o(bb), .busy_o(bub), .done_o(dob), .frame_cnt_o(fcb));

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: the frame currently/last on the wire (start cycle + byte),
  // the holding slot (byte + accept cycle) and the completed-frame count.
  bit         m_act[2];
  int         m_start[2];
  logic [7:0] m_byte[2];
  bit         m_hold[2];
  logic [7:0] m_hbyte[2];
  int         m_hacc[2];
  int         m_frames[2];
  int         acc_cnt[2];

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_hold[i] = 0; m_frames[i] = 0; m_start[i] = 0; m_hacc[i] = 0;
    end
  endtask

  task automatic mstep(input int i, input logic v, input logic [7:0] d);
    int earliest;
    if (m_act[i] && cyc == m_start[i] + DW + 1) m_frames[i]++;
    if (m_hold[i]) begin
      // The held byte starts no earlier than the cycle after its accept and
      // no earlier than the end of the previous frame's gap.
      earliest = m_hacc[i] + 1;
      if (m_act[i] && m_start[i] + DW + gap_of(i) + 1 > earliest)
        earliest = m_start[i] + DW + gap_of(i) + 1;
      if (cyc >= earliest) begin
        m_act[i] = 1; m_start[i] = cyc; m_byte[i] = m_hbyte[i]; m_hold[i] = 0;
      end
    end else if (v === 1'b1) begin
      m_hold[i] = 1; m_hbyte[i] = d; m_hacc[i] = cyc; acc_cnt[i]++;
    end
  endtask

  always @(posedge rst) mreset();

  always @(posedge clk_i) begin
    cyc++;
    if (rst) mreset();
    else begin
      mstep(0, va, da);
      mstep(1, vb, db);
    end
  end

  always @(negedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      int off;
      logic es, eb, ebusy, ed, er;
      logic [15:0] ec;
      off   = m_act[i] ? (cyc - m_start[i]) : -1;
      es    = (off == 0);
      eb    = (off >= 1 && off <= DW) ? m_byte[i][DW - off] : 1'b0;
      ed    = (off == DW);
      ebusy = (off >= 0 && off <= DW + gap_of(i));
      er    = !m_hold[i];
      ec    = (i == 0) ? 16'(m_frames[i]) : 16'(m_frames[i] & 4'hF);
      if (i == 0) begin
        check("a_set", 32'(sa), 32'(es));   check("a_bit", 32'(ba), 32'(eb));
        check("a_done", 32'(doa), 32'(ed)); check("a_busy", 32'(bua), 32'(ebusy));
        check("a_ready", 32'(ra), 32'(er)); check("a_cnt", 32'(fca), 32'(ec));
      end else begin
        check("b_set", 32'(sb), 32'(es));   check("b_bit", 32'(bb), 32'(eb));
        check("b_done", 32'(dob), 32'(ed)); check("b_busy", 32'(bub), 32'(ebusy));
        check("b_ready", 32'(rb), 32'(er)); check("b_cnt", 32'(fcb), 32'(ec));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input logic v, input logic [7:0] d);
    if (i == 0) begin va = v; da = d; end
    else        begin vb = v; db = d; end
  endtask

  function automatic logic o_set(input int i);   return (i == 0) ? sa  : sb;  endfunction
  function automatic logic o_done(input int i);  return (i == 0) ? doa : dob; endfunction
  function automatic logic o_ready(input int i); return (i == 0) ? ra  : rb;  endfunction
  function automatic logic o_busy(input int i);  return (i == 0) ? bua : bub; endfunction

  // Present a byte and wait (bounded) for the model to see it accepted.
  task automatic send(input int i, input logic [7:0] d, input bit keep);
    int c0 = acc_cnt[i];
    int n  = 0;
    drive(i, 1'b1, d);
    while (acc_cnt[i] == c0 && n < 100) begin @(posedge clk_i); #1; n++; end
    check("accept_seen", 32'(acc_cnt[i] != c0), 32'd1);
    if (!keep) drive(i, 1'b0, d);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk_i);
    while ((o_busy(i) || !o_ready(i)) && n < 100) begin @(negedge clk_i); n++; end
  endtask

  task automatic wait_set_a();
    int n = 0;
    @(negedge clk_i);
    while (sa !== 1'b1 && n < 40) begin @(negedge clk_i); n++; end
    check("a_set_seen", 32'(sa), 32'd1);
  endtask

  task automatic capture_a(output logic [7:0] bits, output logic [7:0] dones);
    bits = '0; dones = '0;
    wait_set_a();
    for (int k = 0; k < DW; k++) begin
      @(negedge clk_i);
      bits  = {bits[6:0], ba};
      dones = {dones[6:0], doa};
    end
  endtask

  // A Moore 01011 detector reset by set_o sees the frame's bits only.
  function automatic logic has_01011(input logic [7:0] b);
    for (int s = 0; s <= 3; s++) if (b[7-s -: 5] == 5'b01011) return 1'b1;
    return 1'b0;
  endfunction

  task automatic b2b(input int i);
    int dcyc = -1;
    int scyc = -1;
    wait_idle(i);
    @(posedge clk_i); #1;
    send(i, 8'h2C, 1'b1);
    send(i, 8'h3F, 1'b0);
    @(negedge clk_i);
    check(i == 0 ? "a_ready_full" : "b_ready_full", 32'(o_ready(i)), 32'd0);
    for (int n = 0; n < 40 && scyc < 0; n++) begin
      @(negedge clk_i);
      if (dcyc < 0 && o_done(i)) dcyc = cyc;
      else if (dcyc >= 0 && o_set(i)) scyc = cyc;
    end
    check(i == 0 ? "a_b2b_idle" : "b_b2b_idle", 32'(scyc - dcyc - 1), 32'(gap_of(i)));
  endtask

  task automatic rand_src(input int i, input int ncyc);
    bit pend = 0;
    int c0   = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_i); #1;
      if (pend && acc_cnt[i] != c0) pend = 0;
      if (!pend) begin
        if ($urandom_range(0, 2) != 0) begin
          pend = 1; c0 = acc_cnt[i]; drive(i, 1'b1, 8'($urandom));
        end else begin
          drive(i, 1'b0, 8'($urandom));
        end
      end
    end
    drive(i, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;  // serial order, first bit in [7]
    logic       exp_det;
  } vec_t;

  vec_t vecs[7];
  int   frames_a;

  initial begin
    logic [7:0] bits, dones;
    int dn, prev_done;

    vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0};
    vecs[1] = '{8'h2C, 8'b0010_1100, 1'b1};
    vecs[2] = '{8'h3F, 8'b0011_1111, 1'b0};
    vecs[3] = '{8'h00, 8'b0000_0000, 1'b0};
    vecs[4] = '{8'hFF, 8'b1111_1111, 1'b0};
    vecs[5] = '{8'h81, 8'b1000_0001, 1'b0};
    vecs[6] = '{8'h5A, 8'b0101_1010, 1'b1};
    mreset();
    for (int i = 0; i < 2; i++) acc_cnt[i] = 0;

    // Reset held with valid high: idle outputs and nothing taken.
    rst = 1'b1; drive(0, 1'b1, 8'hA5);
    repeat (4) begin
      @(negedge clk_i);
      check("rst_set", 32'(sa), 32'd0);   check("rst_bit", 32'(ba), 32'd0);
      check("rst_busy", 32'(bua), 32'd0); check("rst_done", 32'(doa), 32'd0);
      check("rst_cnt", 32'(fca), 32'd0);  check("rst_ready", 32'(ra), 32'd1);
    end
    @(posedge clk_i); #1 rst = 1'b0;
    frames_a = 0;

    // Table of single frames on instance a.
    foreach (vecs[v]) begin
      send(0, vecs[v].data, 1'b0);
      capture_a(bits, dones);
      frames_a++;
      check("tbl_bits", 32'(bits), 32'(vecs[v].exp_bits));
      check("tbl_done", 32'(dones), 32'h01);
      check("tbl_det", 32'(has_01011(bits)), 32'(vecs[v].exp_det));
      @(negedge clk_i);
      check("tbl_cnt", 32'(fca), 32'(frames_a));
    end

    // Back-to-back spacing on both gap settings.
    b2b(0);
    b2b(1);

    // Reset during the 4th data bit with the hold slot occupied.
    wait_idle(0);
    @(posedge clk_i); #1;
    send(0, 8'h5A, 1'b1);
    drive(0, 1'b1, 8'h77);
    wait_set_a();
    repeat (4) @(negedge clk_i);
    #2 rst = 1'b1; drive(0, 1'b0, 8'h00);
    #1;
    check("mid_set", 32'(sa), 32'd0);   check("mid_bit", 32'(ba), 32'd0);
    check("mid_busy", 32'(bua), 32'd0); check("mid_done", 32'(doa), 32'd0);
    check("mid_cnt", 32'(fca), 32'd0);  check("mid_ready", 32'(ra), 32'd1);
    check("mid_cnt_b", 32'(fcb), 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1 rst = 1'b0;
    send(0, 8'h81, 1'b0);
    capture_a(bits, dones);
    check("post_rst_bits", 32'(bits), 32'h81);
    check("post_rst_done", 32'(dones), 32'h01);
    @(negedge clk_i);
    check("post_rst_cnt", 32'(fca), 32'd1);

    // Sixteen back-to-back frames on the 4-bit counter instance.
    dn = 0; prev_done = 0;
    fork
      for (int k = 0; k < 16; k++) send(1, 8'(k * 17 + 3), k < 15);
      for (int n = 0; n < 250; n++) begin
        @(negedge clk_i);
        if (prev_done != 0) begin
          if (dn == 15) check("wrap_15", 32'(fcb), 32'd15);
          if (dn == 16) check("wrap_0", 32'(fcb), 32'd0);
        end
        if (dob) dn++;
        prev_done = dob;
      end
    join
    check("wrap_dones", 32'(dn), 32'd16);

    // Random traffic on both instances, checked by the model every cycle.
    fork
      rand_src(0, 1500);
      rand_src(1, 1500);
    join
    repeat (30) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
